// File: rtl/aes256_key_expansion.sv
// aes256_key_expansion
//   Iterative AES-256 key schedule. A load captures the 256-bit cipher key as
//   round keys 0 and 1. The block then produces round keys 2..14, one per clock.
//   All 15 round keys are registered and held until the next load.
//
// Ports
//   sys_clk          system clock; all flops on the rising edge
//   sys_rst          synchronous active-high reset; highest priority
//   key_in[255:0]    cipher key, w[0] in [255:224] ... w[7] in [31:0]
//   key_load         single-cycle strobe; key_in is sampled on the same edge
//   key_zeroize      (KEY_EXP_ZEROIZE_EN only) clears all keys and returns to idle
//   busy             expansion in progress
//   keys_valid       all 15 round keys are valid and stable
//   key_initial      round key 0
//   key_round1..13   round keys 1..13
//   key_finalround   round key 14
//
// Build option
//   KEY_EXP_ZEROIZE_EN : adds the key_zeroize input. It overrides key_load,
//                        and sys_rst overrides it.
module aes256_key_expansion (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic [255:0] key_in,
  input  logic         key_load,
`ifdef KEY_EXP_ZEROIZE_EN
  input  logic         key_zeroize,
`endif
  output logic         busy,
  output logic         keys_valid,
  output logic [127:0] key_initial,
  output logic [127:0] key_round1,
  output logic [127:0] key_round2,
  output logic [127:0] key_round3,
  output logic [127:0] key_round4,
  output logic [127:0] key_round5,
  output logic [127:0] key_round6,
  output logic [127:0] key_round7,
  output logic [127:0] key_round8,
  output logic [127:0] key_round9,
  output logic [127:0] key_round10,
  output logic [127:0] key_round11,
  output logic [127:0] key_round12,
  output logic [127:0] key_round13,
  output logic [127:0] key_finalround
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b,
    8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0, 8'hb7, 8'hfd, 8'h93, 8'h26,
    8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2,
    8'heb, 8'h27, 8'hb2, 8'h75, 8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84, 8'h53, 8'hd1, 8'h00, 8'hed,
    8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f,
    8'h50, 8'h3c, 8'h9f, 8'ha8, 8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2, 8'hcd, 8'h0c, 8'h13, 8'hec,
    8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14,
    8'hde, 8'h5e, 8'h0b, 8'hdb, 8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79, 8'he7, 8'hc8, 8'h37, 8'h6d,
    8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f,
    8'h4b, 8'hbd, 8'h8b, 8'h8a, 8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e, 8'he1, 8'hf8, 8'h98, 8'h11,
    8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f,
    8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Index is rc/2, valid range 1..7.
  function automatic logic [7:0] rcon(input logic [2:0] idx);
    logic [7:0] r;
    r = 8'h00;
    case (idx)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e       state_q;
  logic [3:0]   rc_q;
  logic         settle_q;
  logic [127:0] rk_q [15];

  logic [31:0]  last_word;
  logic [127:0] base_key;
  logic [31:0]  temp;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] new_key;

  // Round key rc from keys rc-2 and rc-1. rc stays within 2..14, so both reads
  // stay inside the register file.
  always_comb begin
    last_word = rk_q[rc_q - 4'd1][31:0];
    base_key  = rk_q[rc_q - 4'd2];
    if (!rc_q[0]) begin
      temp = sub_word({last_word[23:0], last_word[31:24]}) ^ {rcon(rc_q[3:1]), 24'h000000};
    end else begin
      temp = sub_word(last_word);
    end
    w0      = base_key[127:96] ^ temp;
    w1      = base_key[95:64]  ^ w0;
    w2      = base_key[63:32]  ^ w1;
    w3      = base_key[31:0]   ^ w2;
    new_key = {w0, w1, w2, w3};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      rc_q       <= 4'd2;
      settle_q   <= 1'b0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i < 15; i++) rk_q[i] <= '0;
    end
`ifdef KEY_EXP_ZEROIZE_EN
    else if (key_zeroize) begin
      state_q    <= StIdle;
      rc_q       <= 4'd2;
      settle_q   <= 1'b0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i < 15; i++) rk_q[i] <= '0;
    end
`endif
    else if (key_load) begin
      // Any state, including mid-expansion: restart from the new key.
      state_q    <= StExpand;
      rc_q       <= 4'd2;
      settle_q   <= 1'b1;
      busy       <= 1'b1;
      keys_valid <= 1'b0;
      rk_q[0]    <= key_in[255:128];
      rk_q[1]    <= key_in[127:0];
    end else begin
      unique case (state_q)
        StIdle, StDone: ;
        StExpand: begin
          // The cycle right after a load writes nothing, so round key 2 lands
          // two edges after the load and round key 14 fourteen edges after.
          if (settle_q) begin
            settle_q <= 1'b0;
          end else begin
            rk_q[rc_q] <= new_key;
            if (rc_q == 4'd14) begin
              state_q    <= StDone;
              busy       <= 1'b0;
              keys_valid <= 1'b1;
            end else begin
              rc_q <= rc_q + 4'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign key_initial    = rk_q[0];
  assign key_round1     = rk_q[1];
  assign key_round2     = rk_q[2];
  assign key_round3     = rk_q[3];
  assign key_round4     = rk_q[4];
  assign key_round5     = rk_q[5];
  assign key_round6     = rk_q[6];
  assign key_round7     = rk_q[7];
  assign key_round8     = rk_q[8];
  assign key_round9     = rk_q[9];
  assign key_round10    = rk_q[10];
  assign key_round11    = rk_q[11];
  assign key_round12    = rk_q[12];
  assign key_round13    = rk_q[13];
  assign key_finalround = rk_q[14];

endmodule

// File: tb/tb_aes256_key_expansion.sv
module tb_aes256_key_expansion;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic [255:0] key_in = '0;
  logic         key_load = 1'b0;
`ifdef KEY_EXP_ZEROIZE_EN
  logic         key_zeroize = 1'b0;
`endif
  logic         busy;
  logic         keys_valid;
  logic [127:0] rk [15];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] KeyA3 =
    256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [127:0] A3Round2 = 128'h9ba35411_8e6925af_a51a8b5f_2067fcde;
  localparam logic [127:0] A3Final  = 128'hfe4890d1_e6188d0b_046df344_706c631e;
  localparam logic [127:0] ZeroRound2 = 128'h62636363_62636363_62636363_62636363;

  logic [7:0]   sbox_tb [256];
  logic [127:0] exp_rk [15];

  always #5 sys_clk = ~sys_clk;

  aes256_key_expansion dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .key_in         (key_in),
    .key_load       (key_load),
`ifdef KEY_EXP_ZEROIZE_EN
    .key_zeroize    (key_zeroize),
`endif
    .busy           (busy),
    .keys_valid     (keys_valid),
    .key_initial    (rk[0]),
    .key_round1     (rk[1]),
    .key_round2     (rk[2]),
    .key_round3     (rk[3]),
    .key_round4     (rk[4]),
    .key_round5     (rk[5]),
    .key_round6     (rk[6]),
    .key_round7     (rk[7]),
    .key_round8     (rk[8]),
    .key_round9     (rk[9]),
    .key_round10    (rk[10]),
    .key_round11    (rk[11]),
    .key_round12    (rk[12]),
    .key_round13    (rk[13]),
    .key_finalround (rk[14])
  );

  // ---------------- reference model: GF(2^8) S-box and FIPS-197 schedule -----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = v[7:0];
      inv = 8'h00;
      if (x != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, x);
      end
      sbox_tb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
  endfunction

  task automatic compute_model(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k < 15; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Drive a one-cycle load; returns just after the load edge.
  task automatic load_key(input logic [255:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_checks++;
    if (keys_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b, expected 0", keys_valid);
    end
    for (int k = 0; k < 15; k++) begin
      n_checks++;
      if (rk[k] !== 128'h0) begin
        n_fail++; $display("FAIL reset_key%0d: got %h, expected 0", k, rk[k]);
      end
    end
  endtask

  task automatic test_fips_a3();
    compute_model(KeyA3);
    load_key(KeyA3);
    n_checks++;
    if (busy !== 1'b1 || keys_valid !== 1'b0) begin
      n_fail++; $display("FAIL a3_after_load: busy=%b valid=%b, expected 1/0", busy, keys_valid);
    end
    for (int k = 1; k <= 14; k++) begin
      tick();
      n_checks++;
      if (busy !== (k < 14) || keys_valid !== (k == 14)) begin
        n_fail++;
        $display("FAIL a3_flags_edge%0d: busy=%b valid=%b, expected %b/%b",
                 k, busy, keys_valid, k < 14, k == 14);
      end
      if (k == 1) begin
        n_checks++;
        if (rk[2] !== 128'h0) begin
          n_fail++; $display("FAIL a3_round2_early: got %h, expected 0", rk[2]);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (rk[2] !== A3Round2) begin
          n_fail++; $display("FAIL a3_round2: got %h, expected %h", rk[2], A3Round2);
        end
      end
    end
    n_checks++;
    if (rk[14] !== A3Final) begin
      n_fail++; $display("FAIL a3_final: got %h, expected %h", rk[14], A3Final);
    end
    for (int k = 0; k < 15; k++) begin
      n_checks++;
      if (rk[k] !== exp_rk[k]) begin
        n_fail++; $display("FAIL a3_key%0d: got %h, expected %h", k, rk[k], exp_rk[k]);
      end
    end
  endtask

  task automatic test_random_keys();
    logic [255:0] k;
    for (int it = 0; it < 5; it++) begin
      k = rand_key();
      compute_model(k);
      load_key(k);
      for (int e = 1; e <= 14; e++) begin
        tick();
        n_checks++;
        if (busy !== (e < 14) || keys_valid !== (e == 14)) begin
          n_fail++;
          $display("FAIL rand%0d_flags_edge%0d: busy=%b valid=%b, expected %b/%b",
                   it, e, busy, keys_valid, e < 14, e == 14);
        end
      end
      for (int r = 0; r < 15; r++) begin
        n_checks++;
        if (rk[r] !== exp_rk[r]) begin
          n_fail++; $display("FAIL rand%0d_key%0d: got %h, expected %h", it, r, rk[r], exp_rk[r]);
        end
      end
    end
  endtask

  task automatic test_restart();
    compute_model(256'h0);
    load_key(KeyA3);
    for (int e = 1; e <= 4; e++) tick();
    load_key(256'h0);  // edge N+5
    for (int e = 1; e <= 14; e++) begin
      tick();
      n_checks++;
      if (keys_valid !== (e == 14)) begin
        n_fail++;
        $display("FAIL restart_valid_edge%0d: got %b, expected %b", e + 5, keys_valid, e == 14);
      end
    end
    n_checks++;
    if (rk[2] !== ZeroRound2) begin
      n_fail++; $display("FAIL restart_round2: got %h, expected %h", rk[2], ZeroRound2);
    end
    for (int r = 0; r < 15; r++) begin
      n_checks++;
      if (rk[r] !== exp_rk[r]) begin
        n_fail++; $display("FAIL restart_key%0d: got %h, expected %h", r, rk[r], exp_rk[r]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    load_key(rand_key());
    for (int e = 1; e <= 6; e++) tick();
    sys_rst = 1'b1;
    tick();  // edge N+7
    sys_rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || keys_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags: busy=%b valid=%b, expected 0/0", busy, keys_valid);
    end
    for (int r = 0; r < 15; r++) begin
      n_checks++;
      if (rk[r] !== 128'h0) begin
        n_fail++; $display("FAIL rstmid_key%0d: got %h, expected 0", r, rk[r]);
      end
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || keys_valid !== 1'b0 || rk[14] !== 128'h0) begin
      n_fail++;
      $display("FAIL rstmid_idle: busy=%b valid=%b final=%h, expected idle zeros",
               busy, keys_valid, rk[14]);
    end
    k = rand_key();
    compute_model(k);
    load_key(k);
    for (int e = 1; e <= 14; e++) tick();
    n_checks++;
    if (keys_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_reload_flags: busy=%b valid=%b, expected 0/1", busy, keys_valid);
    end
    for (int r = 0; r < 15; r++) begin
      n_checks++;
      if (rk[r] !== exp_rk[r]) begin
        n_fail++; $display("FAIL rstmid_key%0d_reload: got %h, expected %h", r, rk[r], exp_rk[r]);
      end
    end
  endtask

  // Runs from DONE with exp_rk holding the current key set.
  task automatic test_hold_done();
    logic         bad;
    logic [255:0] k;
    k = {exp_rk[0], exp_rk[1]};
    for (int c = 0; c < 50; c++) begin
      tick();
      bad = (keys_valid !== 1'b1) || (busy !== 1'b0);
      for (int r = 0; r < 15; r++) if (rk[r] !== exp_rk[r]) bad = 1'b1;
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid=%b busy=%b final=%h, expected 1/0 %h",
                 c, keys_valid, busy, rk[14], exp_rk[14]);
      end
    end
    load_key(k);
    n_checks++;
    if (keys_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_reload_drop: got %b, expected 0", keys_valid);
    end
    for (int e = 1; e <= 14; e++) begin
      tick();
      n_checks++;
      if (keys_valid !== (e == 14)) begin
        n_fail++; $display("FAIL hold_reload_valid_edge%0d: got %b, expected %b",
                           e, keys_valid, e == 14);
      end
    end
    for (int r = 0; r < 15; r++) begin
      n_checks++;
      if (rk[r] !== exp_rk[r]) begin
        n_fail++; $display("FAIL hold_reload_key%0d: got %h, expected %h", r, rk[r], exp_rk[r]);
      end
    end
  endtask

  task automatic test_load_held();
    logic [255:0] k;
    key_load = 1'b1;
    key_in = rand_key();
    tick();
    key_in = rand_key();
    tick();
    k = rand_key();
    key_in = k;
    tick();  // last high edge
    key_load = 1'b0;
    compute_model(k);
    for (int e = 1; e <= 14; e++) begin
      tick();
      n_checks++;
      if (busy !== (e < 14) || keys_valid !== (e == 14)) begin
        n_fail++;
        $display("FAIL held_flags_edge%0d: busy=%b valid=%b, expected %b/%b",
                 e, busy, keys_valid, e < 14, e == 14);
      end
    end
    for (int r = 0; r < 15; r++) begin
      n_checks++;
      if (rk[r] !== exp_rk[r]) begin
        n_fail++; $display("FAIL held_key%0d: got %h, expected %h", r, rk[r], exp_rk[r]);
      end
    end
  endtask

`ifdef KEY_EXP_ZEROIZE_EN
  task automatic test_zeroize();
    load_key(KeyA3);
    tick();
    tick();
    key_zeroize = 1'b1;
    key_load    = 1'b1;
    key_in      = rand_key();
    tick();  // edge N+3
    key_zeroize = 1'b0;
    key_load    = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || keys_valid !== 1'b0) begin
      n_fail++; $display("FAIL zeroize_flags: busy=%b valid=%b, expected 0/0", busy, keys_valid);
    end
    for (int r = 0; r < 15; r++) begin
      n_checks++;
      if (rk[r] !== 128'h0) begin
        n_fail++; $display("FAIL zeroize_key%0d: got %h, expected 0", r, rk[r]);
      end
    end
    for (int e = 0; e < 16; e++) tick();
    n_checks++;
    if (busy !== 1'b0 || keys_valid !== 1'b0 || rk[2] !== 128'h0) begin
      n_fail++;
      $display("FAIL zeroize_idle: busy=%b valid=%b r2=%h, expected idle zeros",
               busy, keys_valid, rk[2]);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    build_sbox();
    test_reset();
    test_fips_a3();
    test_random_keys();
    test_restart();
    test_reset_mid();
    test_hold_done();
    test_load_held();
`ifdef KEY_EXP_ZEROIZE_EN
    test_zeroize();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes256_key_expansion.md
Name: aes256_key_expansion

Overview:
Iterative AES-256 key schedule that sits directly upstream of AES_datapath. It takes a 256-bit cipher key and produces all 15 128-bit round keys, one round key per clock after load. Each output drives the same-named key input of AES_datapath. Outputs are held stable until the next load, so the pipelined datapath can run continuously on a fixed key.

Parameters:
None. The block is AES-256 only: 15 round keys, Nk=8, 60 words.

Ports:
sys_clk  input  1  system clock; all flops on rising edge
sys_rst  input  1  synchronous, active-high reset
key_in  input  256  cipher key; bits [255:224] = w[0], bits [31:0] = w[7]
key_load  input  1  single-cycle strobe; key_in is sampled on the same edge
busy  output  1  expansion in progress
keys_valid  output  1  all 15 round keys are valid and stable
key_initial  output  128  round key 0 = w[0..3]; w[0] in bits [127:96]
key_round1 .. key_round13  output  128 each  round key k = w[4k..4k+3]; w[4k] in bits [127:96]
key_finalround  output  128  round key 14 = w[56..59]

Behaviour:
- Reset (sys_rst sampled high): FSM goes to IDLE; busy=0; keys_valid=0; all 15 key registers = 0.
- sys_rst has priority over key_load and over the optional zeroize input.
- FSM states:
  - IDLE → EXPAND on key_load.
  - EXPAND → DONE when the round counter is 14.
  - DONE → EXPAND on key_load.
  - EXPAND + key_load → restart EXPAND with the new key. Partial results are discarded and the counter is reset to 2.
- Load edge (cycle N):
  - key_initial ← key_in[255:128] and key_round1 ← key_in[127:0].
  - 4-bit round counter rc ← 2; busy=1 and keys_valid=0 from cycle N+1.
- EXPAND, one round key per cycle. Round key rc is built from keys rc-2 and rc-1:
  - temp = last word of key rc-1.
  - Even rc: temp = SubWord(RotWord(temp)) ^ {Rcon[rc/2],24'h0}, with Rcon[1..7] = 01,02,04,08,10,20,40.
  - Odd rc: temp = SubWord(temp), no rotation and no Rcon.
  - word0 = key[rc-2].word0 ^ temp; then wordj = key[rc-2].wordj ^ word(j-1) for j=1..3, chained combinationally within the cycle.
  - Write the result to key register rc; then rc ← rc+1.
- Timing: key_round2 is written at edge N+2 and key_finalround at edge N+14.
  - On that same edge N+14, the FSM enters DONE with busy=0 and keys_valid=1.
  - Total latency from the load edge to keys_valid is 14 cycles.
- Key registers not yet rewritten keep their previous contents during EXPAND. Consumers must use them only while keys_valid=1.
- DONE: all outputs are frozen. key_load with no key change still re-expands, and keys_valid drops for 14 cycles.
- rc never exceeds 14 and never wraps. In IDLE and DONE, rc is don't-care but held.
- S-box: internal constant 256-entry table, 4 instances for SubWord, purely combinational. There is no registered lookup, so one round key is produced per cycle.
- key_load held high for several cycles restarts every cycle. keys_valid asserts 14 cycles after the last high cycle.

Optional Feature:
KEY_EXP_ZEROIZE_EN
- Defined:
  - Adds port key_zeroize (input, 1 bit, synchronous).
  - When sampled high, all 15 key registers are cleared to 0, keys_valid=0, busy=0 and the FSM goes to IDLE on the next edge.
  - key_zeroize has priority over key_load; sys_rst still has priority over it.
- Undefined: the port does not exist, and key registers are cleared only by sys_rst.

Test Plan:
1. Reset: hold sys_rst 2 cycles, then release → busy=0, keys_valid=0, all 15 key outputs = 0.
2. FIPS-197 A.3: load key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 at edge N →
   - key_round2 = 9ba35411_8e6925af_a51a8b5f_2067fcde at N+2;
   - key_finalround = fe4890d1_e6188d0b_046df344_706c631e at N+14;
   - keys_valid first high at N+14; busy high for exactly N+1..N+13.
3. Restart mid-expansion: load the A.3 key, then at N+5 load the all-zero key →
   - keys_valid first high at N+19;
   - key_round2 = 62636363_62636363_62636363_62636363;
   - no A.3 residue remains in any key output.
4. Reset mid-operation: assert sys_rst at N+7 → at the next edge all keys are 0 and the FSM is in IDLE; a new load afterwards expands normally.
5. Hold in DONE: after valid A.3 keys, run 50 idle cycles → outputs unchanged, keys_valid stays 1; a reload of the same key gives keys_valid=0 for 14 cycles, then identical keys.
6. With KEY_EXP_ZEROIZE_EN: assert key_zeroize and key_load together at N+3 → next cycle all keys are 0, keys_valid=0, busy=0 (zeroize wins).
